sprite_frame_scheduler: RTL and testbench

- Sequences per-frame updates of up to N_SPRITES sprite drivers on the 640x480 display path.
- Detects the start of vertical blank, freezes the synchronized controller buttons for the frame, and issues one update strobe per sprite in fixed order with req/ack handshakes and a timeout.
- In parallel, arbitrates the per-pixel sprite colors by fixed priority with colour-key transparency and produces one registered pixel color for the VGA output stage.

---
 rtl/sprite_frame_scheduler.sv | 207 ++++++++++++++++++++
 tb/tb_sprite_frame_scheduler.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_frame_scheduler.sv
// Per-frame sprite update sequencer with req/ack timeout, plus a fixed-priority
// colour-keyed pixel compositor feeding the VGA output stage.
module sprite_frame_scheduler #(
  parameter int          N_SPRITES   = 4,
  parameter int          H_ACTIVE    = 640,
  parameter int          V_ACTIVE    = 480,
  parameter logic [11:0] TRANSPARENT = 12'hEEE,
  parameter logic [11:0] BG_COLOR    = 12'h000,
  parameter int          ACK_TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [10:0]               drawX,
  input  logic [10:0]               drawY,
  input  logic [3:0]                controls_raw,
  input  logic [12*N_SPRITES-1:0]   sprite_color,
  input  logic [N_SPRITES-1:0]      upd_ack,
  input  logic                      err_clr,
  output logic [N_SPRITES-1:0]      upd_stb,
  output logic [3:0]                ctrl_frame,
  output logic [11:0]               pixel_color,
  output logic [2:0]                pixel_src,
  output logic                      busy,
  output logic                      frame_done,
  output logic [N_SPRITES-1:0]      timeout_err,
  output logic                      overrun_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_NEXT  = 2'd3;

  localparam int            TW       = $clog2(ACK_TIMEOUT + 1);
  localparam logic [2:0]    LAST_IDX = 3'(N_SPRITES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);
  localparam logic [2:0]    SRC_NONE = 3'd7;

  function automatic logic [N_SPRITES-1:0] f_onehot(input logic [2:0] idx);
    logic [N_SPRITES-1:0] v;
    v = '0;
    for (int i = 0; i < N_SPRITES; i++) begin
      if (3'(i) == idx) begin
        v[i] = 1'b1;
      end else begin
        v[i] = 1'b0;
      end
    end
    return v;
  endfunction

  logic [3:0]           r_sync1;
  logic [3:0]           r_sync2;
  logic                 r_vb_d;
  logic [1:0]           r_state;
  logic [2:0]           r_idx;
  logic [TW-1:0]        r_timer;
  logic [N_SPRITES-1:0] r_upd_stb;
  logic [3:0]           r_ctrl_frame;
  logic                 r_busy;
  logic                 r_frame_done;
  logic [N_SPRITES-1:0] r_timeout_err;
  logic                 r_overrun_err;
  logic [11:0]          r_pixel_color;
  logic [2:0]           r_pixel_src;

  logic                 w_vb;
  logic                 w_frame_evt;
  logic                 w_evt_accept;
  logic                 w_evt_overrun;
  logic [N_SPRITES-1:0] w_sel;
  logic                 w_ack_cur;
  logic [1:0]           w_state_nxt;
  logic [2:0]           w_idx_nxt;
  logic [TW-1:0]        w_timer_nxt;
  logic [N_SPRITES-1:0] w_tmo_set;
  logic [11:0]          w_pix_color;
  logic [2:0]           w_pix_src;
  logic                 w_hit;

  // Edge-detected entry into vertical blank; fires once however long the position holds.
  assign w_vb          = (drawX == 11'd0) && (drawY == 11'(V_ACTIVE));
  assign w_frame_evt   = w_vb & ~r_vb_d;
  assign w_evt_accept  = w_frame_evt && (r_state == S_IDLE);
  assign w_evt_overrun = w_frame_evt && (r_state != S_IDLE);
  assign w_sel         = f_onehot(r_idx);
  assign w_ack_cur     = |(upd_ack & w_sel);

  // Sequencer next-state, index, ack timer and timeout detection.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_timer_nxt = r_timer;
    w_tmo_set   = '0;
    case (r_state)
      S_IDLE: begin
        if (w_frame_evt) begin
          w_state_nxt = S_ISSUE;
          w_idx_nxt   = 3'd0;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ISSUE: begin
        w_state_nxt = S_WAIT;
        w_timer_nxt = '0;
      end
      S_WAIT: begin
        w_timer_nxt = r_timer + TW'(1);
        if (w_ack_cur) begin
          w_state_nxt = S_NEXT;
        end else if (r_timer == TMO_LAST) begin
          w_tmo_set   = w_sel;
          w_state_nxt = S_NEXT;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_NEXT: begin
        if (r_idx == LAST_IDX) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_ISSUE;
          w_idx_nxt   = r_idx + 3'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_idx_nxt   = 3'd0;
      end
    endcase
  end

  // Fixed-priority compositor: lowest-index opaque sprite wins, blanking outside the active area.
  always_comb begin
    w_pix_color = BG_COLOR;
    w_pix_src   = SRC_NONE;
    w_hit       = 1'b0;
    if ((drawX >= 11'(H_ACTIVE)) || (drawY >= 11'(V_ACTIVE))) begin
      w_pix_color = 12'h000;
      w_pix_src   = SRC_NONE;
    end else begin
      for (int i = 0; i < N_SPRITES; i++) begin
        if (!w_hit && (sprite_color[12*i +: 12] != TRANSPARENT)) begin
          w_pix_color = sprite_color[12*i +: 12];
          w_pix_src   = 3'(i);
          w_hit       = 1'b1;
        end else begin
          w_hit = w_hit;
        end
      end
    end
  end

  // State registers plus outputs decoded from the next state so each lines up with its FSM cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1       <= 4'd0;
      r_sync2       <= 4'd0;
      r_vb_d        <= 1'b0;
      r_state       <= S_IDLE;
      r_idx         <= 3'd0;
      r_timer       <= '0;
      r_upd_stb     <= '0;
      r_ctrl_frame  <= 4'd0;
      r_busy        <= 1'b0;
      r_frame_done  <= 1'b0;
      r_timeout_err <= '0;
      r_overrun_err <= 1'b0;
    end else begin
      r_sync1       <= controls_raw;
      r_sync2       <= r_sync1;
      r_vb_d        <= w_vb;
      r_state       <= w_state_nxt;
      r_idx         <= w_idx_nxt;
      r_timer       <= w_timer_nxt;
      r_upd_stb     <= (w_state_nxt == S_ISSUE) ? f_onehot(w_idx_nxt) : '0;
      r_ctrl_frame  <= w_evt_accept ? r_sync2 : r_ctrl_frame;
      r_busy        <= (w_state_nxt != S_IDLE);
      r_frame_done  <= (w_state_nxt == S_NEXT) && (w_idx_nxt == LAST_IDX);
      // A set in the same cycle as err_clr leaves the flag set.
      r_timeout_err <= (r_timeout_err & ~{N_SPRITES{err_clr}}) | w_tmo_set;
      r_overrun_err <= (r_overrun_err & ~err_clr) | w_evt_overrun;
    end
  end

  // One-cycle registered pixel pipeline stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pixel_color <= 12'h000;
      r_pixel_src   <= SRC_NONE;
    end else begin
      r_pixel_color <= w_pix_color;
      r_pixel_src   <= w_pix_src;
    end
  end

  assign upd_stb     = r_upd_stb;
  assign ctrl_frame  = r_ctrl_frame;
  assign pixel_color = r_pixel_color;
  assign pixel_src   = r_pixel_src;
  assign busy        = r_busy;
  assign frame_done  = r_frame_done;
  assign timeout_err = r_timeout_err;
  assign overrun_err = r_overrun_err;

endmodule

// File: tb/tb_sprite_frame_scheduler.sv
// Directed self-checking bench for sprite_frame_scheduler with N_SPRITES=4.
module tb_sprite_frame_scheduler;

  logic        clk;
  logic        rst;
  logic [10:0] drawX;
  logic [10:0] drawY;
  logic [3:0]  controls_raw;
  logic [47:0] sprite_color;
  logic [3:0]  upd_ack;
  logic        err_clr;
  logic [3:0]  upd_stb;
  logic [3:0]  ctrl_frame;
  logic [11:0] pixel_color;
  logic [2:0]  pixel_src;
  logic        busy;
  logic        frame_done;
  logic [3:0]  timeout_err;
  logic        overrun_err;

  logic [3:0]  ack_en;
  int          checks;
  int          failures;

  sprite_frame_scheduler dut (
    .clk(clk), .rst(rst), .drawX(drawX), .drawY(drawY),
    .controls_raw(controls_raw), .sprite_color(sprite_color),
    .upd_ack(upd_ack), .err_clr(err_clr), .upd_stb(upd_stb),
    .ctrl_frame(ctrl_frame), .pixel_color(pixel_color), .pixel_src(pixel_src),
    .busy(busy), .frame_done(frame_done), .timeout_err(timeout_err),
    .overrun_err(overrun_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sprite models: ack one cycle after their strobe when enabled.
  always @(posedge clk) begin
    if (rst) upd_ack <= 4'b0000;
    else     upd_ack <= upd_stb & ack_en;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) tick;
    checks++; if (upd_stb !== 4'b0000) begin failures++; $display("FAIL reset_stb got=%b exp=0000", upd_stb); end
    checks++; if (ctrl_frame !== 4'b0000) begin failures++; $display("FAIL reset_ctrl got=%b exp=0000", ctrl_frame); end
    checks++; if (pixel_color !== 12'h000) begin failures++; $display("FAIL reset_color got=%h exp=000", pixel_color); end
    checks++; if (pixel_src !== 3'd7) begin failures++; $display("FAIL reset_src got=%0d exp=7", pixel_src); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", frame_done); end
    checks++; if (timeout_err !== 4'b0000) begin failures++; $display("FAIL reset_tmo got=%b exp=0000", timeout_err); end
    checks++; if (overrun_err !== 1'b0) begin failures++; $display("FAIL reset_ovr got=%b exp=0", overrun_err); end
    rst = 1'b0;
  endtask

  // Full frame with prompt acks; c numbers the cycle, the frame_evt cycle being 1.
  task automatic test_frame_sequence;
    int c;
    logic [3:0] exp_stb;
    ack_en = 4'b1111;
    controls_raw = 4'b0101;
    repeat (3) tick;
    drawX = 11'd0; drawY = 11'd480;
    for (int k = 1; k <= 20; k++) begin
      tick;
      c = k + 1;
      exp_stb = (c == 2) ? 4'b0001 : (c == 5) ? 4'b0010 : (c == 8) ? 4'b0100 :
                (c == 11) ? 4'b1000 : 4'b0000;
      checks++; if (upd_stb !== exp_stb) begin failures++; $display("FAIL seq_stb c=%0d got=%b exp=%b", c, upd_stb, exp_stb); end
      checks++; if (frame_done !== (c == 13)) begin failures++; $display("FAIL seq_done c=%0d got=%b exp=%b", c, frame_done, (c == 13)); end
      checks++; if (busy !== (c >= 2 && c <= 13)) begin failures++; $display("FAIL seq_busy c=%0d got=%b exp=%b", c, busy, (c >= 2 && c <= 13)); end
      if (c == 6) controls_raw = 4'b1010;
      if (c == 13) begin
        checks++; if (ctrl_frame !== 4'b0101) begin failures++; $display("FAIL seq_ctrl got=%b exp=0101", ctrl_frame); end
      end
      if (k == 10) drawY = 11'd0;
    end
  endtask

  task automatic test_controls;
    drawX = 11'd0; drawY = 11'd480;
    tick;
    drawY = 11'd0;
    checks++; if (ctrl_frame !== 4'b1010) begin failures++; $display("FAIL ctrl_next got=%b exp=1010", ctrl_frame); end
    repeat (15) tick;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ctrl_idle got=%b exp=0", busy); end
  endtask

  task automatic test_timeout;
    int c;
    int s2c;
    int s3c;
    int dc;
    s2c = -1; s3c = -1; dc = -1;
    ack_en = 4'b1011;
    drawX = 11'd0; drawY = 11'd480;
    for (int k = 1; k <= 100; k++) begin
      tick;
      c = k + 1;
      if (k == 2) drawY = 11'd0;
      if (upd_stb === 4'b0100) s2c = c;
      if (upd_stb === 4'b1000) s3c = c;
      if (frame_done === 1'b1) dc = c;
      if (c == 72) begin
        checks++; if (timeout_err !== 4'b0000) begin failures++; $display("FAIL tmo_early got=%b exp=0000", timeout_err); end
      end
      if (c == 73) begin
        checks++; if (timeout_err !== 4'b0100) begin failures++; $display("FAIL tmo_flag got=%b exp=0100", timeout_err); end
      end
    end
    checks++; if (s2c !== 8) begin failures++; $display("FAIL tmo_s2 got=%0d exp=8", s2c); end
    checks++; if (s3c !== 74) begin failures++; $display("FAIL tmo_s3 got=%0d exp=74", s3c); end
    checks++; if (dc !== 76) begin failures++; $display("FAIL tmo_done got=%0d exp=76", dc); end
    checks++; if (timeout_err !== 4'b0100) begin failures++; $display("FAIL tmo_sticky got=%b exp=0100", timeout_err); end
    err_clr = 1'b1;
    tick;
    err_clr = 1'b0;
    checks++; if (timeout_err !== 4'b0000) begin failures++; $display("FAIL tmo_clr got=%b exp=0000", timeout_err); end
  endtask

  task automatic test_overrun;
    int c;
    int dones;
    dones = 0;
    ack_en = 4'b1111;
    drawX = 11'd0; drawY = 11'd480;
    for (int k = 1; k <= 30; k++) begin
      tick;
      c = k + 1;
      if (frame_done === 1'b1) dones++;
      if (c == 2) controls_raw = 4'b1100;
      if (c == 3) drawY = 11'd0;
      if (c == 5) begin
        checks++; if (overrun_err !== 1'b0) begin failures++; $display("FAIL ovr_early got=%b exp=0", overrun_err); end
        drawY = 11'd480;
      end
      if (c == 6) begin
        checks++; if (overrun_err !== 1'b1) begin failures++; $display("FAIL ovr_flag got=%b exp=1", overrun_err); end
      end
      if (c == 8) drawY = 11'd0;
    end
    checks++; if (dones !== 1) begin failures++; $display("FAIL ovr_dones got=%0d exp=1", dones); end
    checks++; if (ctrl_frame !== 4'b1010) begin failures++; $display("FAIL ovr_ctrl got=%b exp=1010", ctrl_frame); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ovr_busy got=%b exp=0", busy); end
    err_clr = 1'b1;
    tick;
    err_clr = 1'b0;
    checks++; if (overrun_err !== 1'b0) begin failures++; $display("FAIL ovr_clr got=%b exp=0", overrun_err); end
  endtask

  task automatic test_compositor;
    drawX = 11'd100; drawY = 11'd50;
    sprite_color = {12'hEEE, 12'h0F0, 12'hEEE, 12'hEEE};
    tick;
    checks++; if (pixel_color !== 12'h0F0 || pixel_src !== 3'd2) begin failures++; $display("FAIL comp_s2 got=%h/%0d exp=0f0/2", pixel_color, pixel_src); end
    sprite_color = {12'hEEE, 12'hEEE, 12'hEEE, 12'hEEE};
    tick;
    checks++; if (pixel_color !== 12'h000 || pixel_src !== 3'd7) begin failures++; $display("FAIL comp_bg got=%h/%0d exp=000/7", pixel_color, pixel_src); end
    sprite_color = {12'h0AB, 12'hEEE, 12'h123, 12'hEEE};
    tick;
    checks++; if (pixel_color !== 12'h123 || pixel_src !== 3'd1) begin failures++; $display("FAIL comp_s1 got=%h/%0d exp=123/1", pixel_color, pixel_src); end
    sprite_color = {12'h0AB, 12'hEEE, 12'h123, 12'h456};
    tick;
    checks++; if (pixel_color !== 12'h456 || pixel_src !== 3'd0) begin failures++; $display("FAIL comp_s0 got=%h/%0d exp=456/0", pixel_color, pixel_src); end
    drawX = 11'd700;
    tick;
    checks++; if (pixel_color !== 12'h000 || pixel_src !== 3'd7) begin failures++; $display("FAIL comp_outx got=%h/%0d exp=000/7", pixel_color, pixel_src); end
    drawX = 11'd639; drawY = 11'd479;
    sprite_color = {12'h00F, 12'hEEE, 12'hEEE, 12'hEEE};
    tick;
    checks++; if (pixel_color !== 12'h00F || pixel_src !== 3'd3) begin failures++; $display("FAIL comp_edge got=%h/%0d exp=00f/3", pixel_color, pixel_src); end
    drawX = 11'd5; drawY = 11'd480;
    tick;
    checks++; if (pixel_color !== 12'h000 || pixel_src !== 3'd7) begin failures++; $display("FAIL comp_outy got=%h/%0d exp=000/7", pixel_color, pixel_src); end
    drawX = 11'd0; drawY = 11'd0;
    sprite_color = {12'hEEE, 12'hEEE, 12'hEEE, 12'hEEE};
    tick;
  endtask

  task automatic test_reset_mid;
    ack_en = 4'b1101;
    drawX = 11'd0; drawY = 11'd480;
    for (int k = 1; k <= 9; k++) begin
      tick;
      if (k == 2) drawY = 11'd0;
    end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rmid_busy_pre got=%b exp=1", busy); end
    rst = 1'b1;
    #1;
    checks++; if (upd_stb !== 4'b0000 || busy !== 1'b0 || pixel_src !== 3'd7) begin failures++; $display("FAIL rmid_async got=%b/%b/%0d exp=0000/0/7", upd_stb, busy, pixel_src); end
    tick; tick;
    checks++; if (upd_stb !== 4'b0000 || busy !== 1'b0 || pixel_src !== 3'd7) begin failures++; $display("FAIL rmid_hold got=%b/%b/%0d exp=0000/0/7", upd_stb, busy, pixel_src); end
    rst = 1'b0;
    ack_en = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      tick;
      checks++; if (upd_stb !== 4'b0000 || busy !== 1'b0) begin failures++; $display("FAIL rmid_pending got=%b/%b exp=0000/0", upd_stb, busy); end
    end
    drawY = 11'd480;
    tick;
    drawY = 11'd0;
    checks++; if (upd_stb !== 4'b0001 || busy !== 1'b1) begin failures++; $display("FAIL rmid_restart got=%b/%b exp=0001/1", upd_stb, busy); end
    repeat (15) tick;
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; drawX = 11'd0; drawY = 11'd0; controls_raw = 4'b0000;
    sprite_color = {12'hEEE, 12'hEEE, 12'hEEE, 12'hEEE};
    err_clr = 1'b0; ack_en = 4'b1111;
    test_reset;
    test_frame_sequence;
    test_controls;
    test_timeout;
    test_overrun;
    test_compositor;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
